// File: rtl/signed_seq_mult.sv
// Sequential signed multiplier: magnitude shift-add, one bit per clock, sign restored at the end.
// Optional saturation outputs (ovf, p_sat) are enabled by defining MULT_SAT_EN.
module signed_seq_mult #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef MULT_SAT_EN
  ,
  output logic                 ovf,
  output logic [WIDTH-1:0]     p_sat
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   addend, acc_step, product_next;

  always_comb begin
    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;
    // Adding at bit WIDTH-1 after the right shift keeps the running sum aligned so that
    // after WIDTH steps acc holds the full unsigned magnitude product.
    addend   = mag_b[cnt] ? ({{WIDTH{1'b0}}, mag_a} << (WIDTH - 1)) : '0;
    acc_step = (acc >> 1) + addend;
    product_next = neg ? -acc : acc;
  end

`ifdef MULT_SAT_EN
  localparam logic signed [2*WIDTH-1:0] SMAX = (2*WIDTH)'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [2*WIDTH-1:0] SMIN = -(2*WIDTH)'(2 ** (WIDTH - 1));

  logic             ovf_next;
  logic [WIDTH-1:0] p_sat_next;

  always_comb begin
    ovf_next   = ($signed(product_next) > SMAX) || ($signed(product_next) < SMIN);
    p_sat_next = product_next[WIDTH-1:0];
    if (ovf_next)
      p_sat_next = product_next[2*WIDTH-1] ? SMIN[WIDTH-1:0] : SMAX[WIDTH-1:0];
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
`ifdef MULT_SAT_EN
      ovf     <= 1'b0;
      p_sat   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        SIGN: begin
          product <= product_next;
          done    <= 1'b1;
          busy    <= 1'b0;
`ifdef MULT_SAT_EN
          ovf     <= ovf_next;
          p_sat   <= p_sat_next;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_mult.sv
// Directed self-checking bench for signed_seq_mult at WIDTH=4 (saturation checks with MULT_SAT_EN).
module tb_signed_seq_mult;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done;
  logic [7:0] product;
`ifdef MULT_SAT_EN
  logic       ovf;
  logic [3:0] p_sat;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  signed_seq_mult #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
`ifdef MULT_SAT_EN
    ,
    .ovf     (ovf),
    .p_sat   (p_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an operation and waits for done; hold keeps start high so the done-cycle edge
  // can accept the next operation.
  task automatic do_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                       input logic [7:0] exp, input bit hold);
    int lat;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check({tag, "_busy_acc"}, 16'(busy), 16'd1);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 16'(lat), 16'd5);
    check({tag, "_prod"}, 16'(product), 16'(exp));
    check({tag, "_busy_done"}, 16'(busy), 16'd0);
  endtask

  task automatic count_dones(input string tag, input int cycles, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check(tag, 16'(n), 16'(exp));
  endtask

  initial begin
    int lat;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_prod", 16'(product), 16'd0);
`ifdef MULT_SAT_EN
    check("rst_ovf", 16'(ovf), 16'd0);
    check("rst_psat", 16'(p_sat), 16'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    do_op("3x5", 4'h3, 4'h5, 8'h0F, 1'b0);
    @(posedge clk); #1;
    check("done_pulse_low", 16'(done), 16'd0);
    check("prod_held", 16'(product), 16'h0F);

    do_op("m3x5",  4'hD, 4'h5, 8'hF1, 1'b0);
    do_op("7xm8",  4'h7, 4'h8, 8'hC8, 1'b0);
    do_op("m8xm8", 4'h8, 4'h8, 8'h40, 1'b0);
`ifdef MULT_SAT_EN
    check("m8xm8_ovf", 16'(ovf), 16'd1);
    check("m8xm8_psat", 16'(p_sat), 16'h7);
`endif
    do_op("0xm1",  4'h0, 4'hF, 8'h00, 1'b0);
    do_op("m1xm8", 4'hF, 4'h8, 8'h08, 1'b0);
    do_op("1xm8",  4'h1, 4'h8, 8'hF8, 1'b0);
`ifdef MULT_SAT_EN
    check("1xm8_ovf", 16'(ovf), 16'd0);
    check("1xm8_psat", 16'(p_sat), 16'h8);
`endif
    do_op("2xm3",  4'h2, 4'hD, 8'hFA, 1'b0);
`ifdef MULT_SAT_EN
    check("2xm3_ovf", 16'(ovf), 16'd0);
    check("2xm3_psat", 16'(p_sat), 16'hA);
`endif
    do_op("m4x3",  4'hC, 4'h3, 8'hF4, 1'b0);
`ifdef MULT_SAT_EN
    check("m4x3_ovf", 16'(ovf), 16'd1);
    check("m4x3_psat", 16'(p_sat), 16'h8);
`endif
    do_op("7x7",   4'h7, 4'h7, 8'h31, 1'b0);
`ifdef MULT_SAT_EN
    check("7x7_ovf", 16'(ovf), 16'd1);
    check("7x7_psat", 16'(p_sat), 16'h7);
`endif

    // back-to-back: second start accepted on the done-cycle edge
    do_op("b2b_first",  4'h6, 4'hE, 8'hF4, 1'b1);
    do_op("b2b_second", 4'hB, 4'hB, 8'h19, 1'b0);
    count_dones("b2b_no_extra", 8, 0);

    // start pulsed mid-CALC is ignored
    @(negedge clk);
    a = 4'h3; b = 4'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 4'h7; b = 4'h7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    for (int i = 3; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("mid_start_lat", 16'(lat), 16'd5);
    check("mid_start_prod", 16'(product), 16'h09);
    count_dones("mid_start_one_done", 8, 0);

    // asynchronous reset during CALC
    @(negedge clk);
    a = 4'h5; b = 4'hD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_done", 16'(done), 16'd0);
    check("arst_prod", 16'(product), 16'd0);
`ifdef MULT_SAT_EN
    check("arst_ovf", 16'(ovf), 16'd0);
    check("arst_psat", 16'(p_sat), 16'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    count_dones("arst_no_done", 8, 0);
    check("arst_idle_busy", 16'(busy), 16'd0);
    do_op("after_rst", 4'h5, 4'hD, 8'hF1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
